// File: rtl/reset_ctrl.sv
// Central SoC reset generator: merges POR, debounced push-button, software and
// watchdog requests into a staged periph/core release with a sticky cause register.
module reset_ctrl #(
    parameter int HOLD_CYCLES     = 16,
    parameter int STAGGER_CYCLES  = 4,
    parameter int DEBOUNCE_CYCLES = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       sw_rst_req,
    input  logic       wdt_rst_req,
    input  logic       cause_clr,
    output logic       periph_rst_n,
    output logic       core_rst_n,
    output logic       rst_active,
    output logic [3:0] rst_cause
);
    localparam int MAX_HS  = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
    localparam int MAX_CYC = (MAX_HS > DEBOUNCE_CYCLES) ? MAX_HS : DEBOUNCE_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] CNT_ZERO     = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_STAGGER = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    state_t           state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             periph_r, periph_s;
    logic             core_r, core_s;
    logic             active_r, active_s;
    logic [3:0]       cause_r, cause_s;
    logic             btn_meta_r, btn_sync_r;
    logic             btn_pressed_r, btn_pressed_s;
    logic [CNT_W-1:0] db_cnt_r, db_cnt_s;
    logic             req_s;
    logic [3:0]       src_s;

    // A clear replaces the sticky bits with this edge's sources; otherwise accumulate
    function automatic logic [3:0] cause_update_f(
        input logic [3:0] cur,
        input logic [3:0] src,
        input logic       clr
    );
        logic [3:0] res;
        if (clr) begin
            res = src;
        end else begin
            res = cur | src;
        end
        return res;
    endfunction

    // Two-flop synchronizer for the asynchronous button
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_meta_r <= 1'b1;
            btn_sync_r <= 1'b1;
        end else begin
            btn_meta_r <= btn_n;
            btn_sync_r <= btn_meta_r;
        end
    end

    // Debounce: flip pressed state after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_comb begin
        btn_pressed_s = btn_pressed_r;
        db_cnt_s      = CNT_ZERO;
        if ((~btn_sync_r) != btn_pressed_r) begin
            if (db_cnt_r == DB_LAST) begin
                btn_pressed_s = ~btn_pressed_r;
                db_cnt_s      = CNT_ZERO;
            end else begin
                btn_pressed_s = btn_pressed_r;
                db_cnt_s      = db_cnt_r + CNT_ONE;
            end
        end else begin
            db_cnt_s = CNT_ZERO;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_pressed_r <= 1'b0;
            db_cnt_r      <= CNT_ZERO;
        end else begin
            btn_pressed_r <= btn_pressed_s;
            db_cnt_r      <= db_cnt_s;
        end
    end

    assign req_s = btn_pressed_r | sw_rst_req | wdt_rst_req;
    assign src_s = {wdt_rst_req, sw_rst_req, btn_pressed_r, 1'b0};

    // Sequencer next state; outputs are computed as next register values
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        periph_s = periph_r;
        core_s   = core_r;
        active_s = active_r;
        case (state_r)
            ST_HOLD: begin
                periph_s = 1'b0;
                core_s   = 1'b0;
                active_s = 1'b1;
                if (req_s) begin
                    cnt_s = CNT_ZERO;
                end else if (cnt_r == HOLD_LAST) begin
                    periph_s = 1'b1;
                    cnt_s    = CNT_ZERO;
                    state_s  = ST_STAGGER;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_STAGGER: begin
                if (req_s) begin
                    periph_s = 1'b0;
                    cnt_s    = CNT_ZERO;
                    state_s  = ST_HOLD;
                end else if (cnt_r == STAGGER_LAST) begin
                    core_s   = 1'b1;
                    active_s = 1'b0;
                    cnt_s    = CNT_ZERO;
                    state_s  = ST_RUN;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (req_s) begin
                    periph_s = 1'b0;
                    core_s   = 1'b0;
                    active_s = 1'b1;
                    cnt_s    = CNT_ZERO;
                    state_s  = ST_HOLD;
                end else begin
                    cnt_s = CNT_ZERO;
                end
            end
            default: begin
                periph_s = 1'b0;
                core_s   = 1'b0;
                active_s = 1'b1;
                cnt_s    = CNT_ZERO;
                state_s  = ST_HOLD;
            end
        endcase
    end

    // Clear is honoured only once the core is running
    always_comb begin
        cause_s = cause_update_f(cause_r, src_s, cause_clr && (state_r == ST_RUN));
    end

    // Sequencer and reset output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_HOLD;
            cnt_r    <= CNT_ZERO;
            periph_r <= 1'b0;
            core_r   <= 1'b0;
            active_r <= 1'b1;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            periph_r <= periph_s;
            core_r   <= core_s;
            active_r <= active_s;
        end
    end

    // Sticky cause register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cause_r <= 4'b0001;
        end else begin
            cause_r <= cause_s;
        end
    end

    assign periph_rst_n = periph_r;
    assign core_rst_n   = core_r;
    assign rst_active   = active_r;
    assign rst_cause    = cause_r;

    reset_ctrl_chk u_chk (
        .clk          (clk),
        .rst          (rst),
        .periph_rst_n (periph_r),
        .core_rst_n   (core_r),
        .rst_active   (active_r)
    );

endmodule

// Ordering invariants of the staged reset outputs.
module reset_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic periph_rst_n,
    input logic core_rst_n,
    input logic rst_active
);
    a_core_after_periph: assert property (@(posedge clk) disable iff (rst)
        core_rst_n |-> periph_rst_n);

    a_active_tracks_core: assert property (@(posedge clk) disable iff (rst)
        rst_active == ~core_rst_n);
endmodule

// File: tb/tb_reset_ctrl.sv
// Scoreboard bench for reset_ctrl: a quiet-time reference model predicts every cycle.
module tb_reset_ctrl;
    localparam int H = 16;
    localparam int S = 4;
    localparam int D = 8;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic       btn_n = 1'b1;
    logic       sw    = 1'b0;
    logic       wdt   = 1'b0;
    logic       clr   = 1'b0;
    logic       periph_rst_n, core_rst_n, rst_active;
    logic [3:0] rst_cause;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       p;
        logic       c;
        logic       a;
        logic [3:0] cause;
    } exp_t;
    exp_t exp_q[$];

    // reference model state: edges since last request, debounce run length
    int       quiet_m;
    bit       pressed_m;
    int       run_m;
    bit [3:0] cause_m;
    bit       hist_m[$];

    reset_ctrl #(.HOLD_CYCLES(H), .STAGGER_CYCLES(S), .DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .sw_rst_req   (sw),
        .wdt_rst_req  (wdt),
        .cause_clr    (clr),
        .periph_rst_n (periph_rst_n),
        .core_rst_n   (core_rst_n),
        .rst_active   (rst_active),
        .rst_cause    (rst_cause)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        quiet_m   = 0;
        pressed_m = 1'b0;
        run_m     = 0;
        cause_m   = 4'b0001;
        hist_m    = '{1'b1, 1'b1};
    endtask

    // reference model: resets are released once enough request-free edges have passed
    initial begin : model
        bit [3:0] src;
        bit       req, pold, sync_v, in_run;
        exp_t     e;
        model_reset();
        forever begin
            @(posedge clk);
            if (rst) begin
                model_reset();
            end else begin
                pold   = pressed_m;
                sync_v = hist_m.pop_front();
                hist_m.push_back(btn_n);
                req    = pold | sw | wdt;
                in_run = (quiet_m >= H + S);
                src    = {wdt, sw, pold, 1'b0};
                if (clr && in_run) cause_m = src;
                else cause_m = cause_m | src;
                if (req) quiet_m = 0;
                else if (quiet_m < H + S) quiet_m++;
                if ((!sync_v) != pressed_m) run_m++;
                else run_m = 0;
                if (run_m == D) begin
                    pressed_m = !pressed_m;
                    run_m     = 0;
                end
            end
            e.p     = (quiet_m >= H);
            e.c     = (quiet_m >= H + S);
            e.a     = (quiet_m < H + S);
            e.cause = cause_m;
            exp_q.push_back(e);
        end
    end

    // monitor: compare DUT outputs against the model just after each edge
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL sb_empty: got no expectation at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("sb_periph", {3'b000, periph_rst_n}, {3'b000, e.p});
                check("sb_core",   {3'b000, core_rst_n},   {3'b000, e.c});
                check("sb_active", {3'b000, rst_active},   {3'b000, e.a});
                check("sb_cause",  rst_cause,              e.cause);
            end
        end
    end

    task automatic step(input logic s, input logic w, input logic c, input logic b);
        sw    = s;
        wdt   = w;
        clr   = c;
        btn_n = b;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin : stim
        logic btn_v;
        int   btn_left;
        // 1: power-on release timing and clear in RUN
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(15);
        check("por_periph_e15", {3'b000, periph_rst_n}, 4'b0000);
        idle(1);
        check("por_periph_e16", {3'b000, periph_rst_n}, 4'b0001);
        check("por_core_e16",   {3'b000, core_rst_n},   4'b0000);
        idle(3);
        check("por_core_e19",   {3'b000, core_rst_n},   4'b0000);
        idle(1);
        check("por_core_e20",   {3'b000, core_rst_n},   4'b0001);
        check("por_active_e20", {3'b000, rst_active},   4'b0000);
        check("por_cause",      rst_cause,              4'b0001);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("por_clear",      rst_cause,              4'b0000);
        idle(3);
        // 2: software reset, single cycle then held
        step(1'b1, 1'b0, 1'b0, 1'b1);
        check("sw_periph_low",  {3'b000, periph_rst_n}, 4'b0000);
        check("sw_cause",       rst_cause,              4'b0100);
        idle(24);
        for (int i = 0; i < 50; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(25);
        // 3: bouncing button must not reset, a held press must
        for (int i = 0; i < 40; i++) step(1'b0, 1'b0, 1'b0, ((i / 3) % 2) == 0 ? 1'b0 : 1'b1);
        idle(12);
        check("bounce_no_rst",  {3'b000, core_rst_n},   4'b0001);
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        check("btn_cause_bit1", {3'b000, rst_cause[1]}, 4'b0001);
        idle(40);
        // 4: watchdog restart while staggering
        step(1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        idle(17);
        check("stag_periph_up", {3'b000, periph_rst_n}, 4'b0001);
        step(1'b0, 1'b1, 1'b0, 1'b1);
        check("stag_periph_dn", {3'b000, periph_rst_n}, 4'b0000);
        check("stag_cause",     rst_cause,              4'b1000);
        idle(25);
        // 5: simultaneous sources with clear, then clear ignored in HOLD
        step(1'b1, 1'b1, 1'b1, 1'b1);
        check("simul_cause",    rst_cause,              4'b1100);
        idle(5);
        step(1'b0, 1'b0, 1'b1, 1'b1);
        check("hold_clr_ign",   rst_cause,              4'b1100);
        idle(25);
        // 6: asynchronous reset at HOLD count 10
        step(1'b1, 1'b0, 1'b0, 1'b1);
        idle(10);
        rst = 1'b1;
        #1;
        check("async_periph",   {3'b000, periph_rst_n}, 4'b0000);
        check("async_core",     {3'b000, core_rst_n},   4'b0000);
        check("async_active",   {3'b000, rst_active},   4'b0001);
        check("async_cause",    rst_cause,              4'b0001);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(15);
        check("rerel_periph15", {3'b000, periph_rst_n}, 4'b0000);
        idle(1);
        check("rerel_periph16", {3'b000, periph_rst_n}, 4'b0001);
        idle(10);
        // randomized traffic
        btn_v    = 1'b1;
        btn_left = 20;
        for (int i = 0; i < 800; i++) begin
            if (btn_left == 0) begin
                btn_v    = ~btn_v;
                btn_left = $urandom_range(1, 14);
            end
            btn_left--;
            step($urandom_range(0, 39) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 7) == 0, btn_v);
        end
        idle(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
